// File: rtl/ascon_perm_engine_pkg.sv
// rtl/ascon_perm_engine_pkg.sv - Ascon state type, round constant, S-box and linear layer
package ascon_pack;

  localparam int ROUNDS_A = 12;

  typedef struct packed {
    logic [63:0] x0;
    logic [63:0] x1;
    logic [63:0] x2;
    logic [63:0] x3;
    logic [63:0] x4;
  } type_state;

  typedef enum logic {ST_IDLE, ST_RUN} type_fsm;

  localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
  localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

  function automatic logic [63:0] round_const(input logic [3:0] r);
    return {56'd0, 4'hf - r, r};
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // Bit-sliced 5-bit S-box applied to all 64 columns at once
  function automatic type_state sbox(input type_state s);
    type_state a;
    type_state t;
    a = s;
    a.x0 ^= a.x4;
    a.x4 ^= a.x3;
    a.x2 ^= a.x1;
    t.x0 = ~a.x0 & a.x1;
    t.x1 = ~a.x1 & a.x2;
    t.x2 = ~a.x2 & a.x3;
    t.x3 = ~a.x3 & a.x4;
    t.x4 = ~a.x4 & a.x0;
    a.x0 ^= t.x1;
    a.x1 ^= t.x2;
    a.x2 ^= t.x3;
    a.x3 ^= t.x4;
    a.x4 ^= t.x0;
    a.x1 ^= a.x0;
    a.x0 ^= a.x4;
    a.x3 ^= a.x2;
    a.x2 = ~a.x2;
    return a;
  endfunction

  function automatic type_state linear(input type_state s);
    type_state o;
    o.x0 = s.x0 ^ rotr(s.x0, ROT_A[0]) ^ rotr(s.x0, ROT_B[0]);
    o.x1 = s.x1 ^ rotr(s.x1, ROT_A[1]) ^ rotr(s.x1, ROT_B[1]);
    o.x2 = s.x2 ^ rotr(s.x2, ROT_A[2]) ^ rotr(s.x2, ROT_B[2]);
    o.x3 = s.x3 ^ rotr(s.x3, ROT_A[3]) ^ rotr(s.x3, ROT_B[3]);
    o.x4 = s.x4 ^ rotr(s.x4, ROT_A[4]) ^ rotr(s.x4, ROT_B[4]);
    return o;
  endfunction

endpackage

// File: rtl/ascon_perm_engine_if.sv
// rtl/ascon_perm_engine_if.sv - control, data and status bundle of the permutation engine
interface ascon_perm_engine_if;
  import ascon_pack::*;

  logic         start_i;
  logic         mode_i;
  type_state    state_i;
  logic [63:0]  data_i;
  logic [127:0] key_i;
  logic         en_xor_data_i;
  logic         en_xor_key_final_i;
  logic         en_xor_key_i;
  logic         en_xor_lsb_i;
  type_state    state_o;
  logic [63:0]  cipher_o;
  logic [127:0] tag_o;
  logic         busy_o;
  logic         done_o;
  logic [3:0]   round_o;

  modport master (
    output start_i, mode_i, state_i, data_i, key_i,
           en_xor_data_i, en_xor_key_final_i, en_xor_key_i, en_xor_lsb_i,
    input  state_o, cipher_o, tag_o, busy_o, done_o, round_o
  );

  modport slave (
    input  start_i, mode_i, state_i, data_i, key_i,
           en_xor_data_i, en_xor_key_final_i, en_xor_key_i, en_xor_lsb_i,
    output state_o, cipher_o, tag_o, busy_o, done_o, round_o
  );

endinterface

// File: rtl/ascon_round.sv
// rtl/ascon_round.sv - one combinational Ascon round: constant addition, S-box, linear diffusion
module ascon_round
  import ascon_pack::*;
(
  input  type_state  cur,
  input  logic [3:0] round_idx,
  output type_state  nxt
);

  type_state with_const;

  always_comb begin
    with_const    = cur;
    with_const.x2 = cur.x2 ^ round_const(round_idx);
  end

  assign nxt = linear(sbox(with_const));

endmodule

// File: rtl/ascon_perm_engine.sv
// rtl/ascon_perm_engine.sv - iterative Ascon pa/pb permutation with key/data XOR hooks
module ascon_perm_engine
  import ascon_pack::*;
#(
  parameter int UNROLL   = 1,
  parameter int ROUNDS_B = 6
) (
  input logic                clock_i,
  input logic                resetb_i,
  ascon_perm_engine_if.slave bus
);

  localparam logic [3:0] FIRST_B   = 4'(ROUNDS_A - ROUNDS_B);
  localparam logic [3:0] LAST_STEP = 4'(ROUNDS_A - UNROLL);

  type_fsm      fsm_q, fsm_d;
  type_state    state_q;
  logic [63:0]  cipher_q;
  logic [127:0] tag_q;
  logic [127:0] key_q;
  logic [3:0]   round_q;
  logic         done_q;
  logic         en_key_q, en_lsb_q, en_key_final_q;
  logic         accept, finish;
  type_state    loaded, permuted, finished;
  type_state    chain [UNROLL+1];

  assign chain[0] = state_q;
  for (genvar g = 0; g < UNROLL; g++) begin : g_round
    ascon_round u_round (
      .cur       (chain[g]),
      .round_idx (round_q + 4'(g)),
      .nxt       (chain[g+1])
    );
  end
  assign permuted = chain[UNROLL];

  always_comb begin
    fsm_d  = fsm_q;
    accept = 1'b0;
    finish = 1'b0;
    case (fsm_q)
      ST_IDLE: if (bus.start_i) begin
        accept = 1'b1;
        fsm_d  = ST_RUN;
      end
      ST_RUN: if (round_q == LAST_STEP) begin
        finish = 1'b1;
        fsm_d  = ST_IDLE;
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  // Pre-XORs act on the incoming state, post-XORs on the last round's result
  always_comb begin
    loaded = bus.state_i;
    if (bus.en_xor_data_i) loaded.x0 = loaded.x0 ^ bus.data_i;
    if (bus.en_xor_key_final_i) begin
      loaded.x1 = loaded.x1 ^ bus.key_i[127:64];
      loaded.x2 = loaded.x2 ^ bus.key_i[63:0];
    end
    finished = permuted;
    if (en_key_q) begin
      finished.x3 = finished.x3 ^ key_q[127:64];
      finished.x4 = finished.x4 ^ key_q[63:0];
    end
    if (en_lsb_q) finished.x4[0] = ~finished.x4[0];
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) fsm_q <= ST_IDLE;
    else           fsm_q <= fsm_d;
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q        <= '0;
      cipher_q       <= '0;
      tag_q          <= '0;
      key_q          <= '0;
      round_q        <= '0;
      done_q         <= 1'b0;
      en_key_q       <= 1'b0;
      en_lsb_q       <= 1'b0;
      en_key_final_q <= 1'b0;
    end else begin
      done_q <= finish;
      if (accept) begin
        state_q        <= loaded;
        cipher_q       <= loaded.x0;
        round_q        <= bus.mode_i ? FIRST_B : 4'd0;
        key_q          <= bus.key_i;
        en_key_q       <= bus.en_xor_key_i;
        en_lsb_q       <= bus.en_xor_lsb_i;
        en_key_final_q <= bus.en_xor_key_final_i;
      end else if (finish) begin
        state_q <= finished;
        round_q <= 4'd0;
        if (en_key_final_q) tag_q <= {permuted.x3 ^ key_q[127:64], permuted.x4 ^ key_q[63:0]};
      end else if (fsm_q == ST_RUN) begin
        state_q <= permuted;
        round_q <= round_q + 4'(UNROLL);
      end
    end
  end

  assign bus.state_o  = state_q;
  assign bus.cipher_o = cipher_q;
  assign bus.tag_o    = tag_q;
  assign bus.busy_o   = (fsm_q == ST_RUN);
  assign bus.done_o   = done_q;
  assign bus.round_o  = round_q;

endmodule

// File: tb/tb_ascon_perm_engine.sv
// tb/tb_ascon_perm_engine.sv - scoreboard bench for three engine configurations against a table-driven Ascon model
module tb_ascon_perm_engine;
  import ascon_pack::*;

  localparam int NDUT = 3;
  localparam int U_TBL  [NDUT] = '{1, 2, 1};
  localparam int RB_TBL [NDUT] = '{6, 6, 8};
  localparam logic [4:0] SBOX_TBL [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
  localparam int ROT1 [5] = '{19, 61, 1, 10, 7};
  localparam int ROT2 [5] = '{28, 39, 6, 17, 41};
  localparam type_state VEC = '{64'h80400c0600000000, 64'h8a55114d1cb6a9a2,
                                64'hbe263d4d7aecaaff, 64'h4ed0ec0b98c529b7, 64'hc8cddf37bcd0284a};
  localparam logic [127:0] KEY = 128'h8a55114d1cb6a9a2be263d4d7aecaaff;

  typedef struct {
    int           id;
    type_state    st;
    logic [63:0]  ci;
    logic [127:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start, mode, en_d, en_kf, en_k, en_l;
  type_state    st_in;
  logic [63:0]  data;
  logic [127:0] key;

  type_state    st_o   [NDUT];
  logic [63:0]  ci_o   [NDUT];
  logic [127:0] tag_o  [NDUT];
  logic         busy_o [NDUT];
  logic         done_o [NDUT];
  logic [3:0]   rnd_o  [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    ascon_perm_engine_if bus ();
    assign bus.start_i            = start;
    assign bus.mode_i             = mode;
    assign bus.state_i            = st_in;
    assign bus.data_i             = data;
    assign bus.key_i              = key;
    assign bus.en_xor_data_i      = en_d;
    assign bus.en_xor_key_final_i = en_kf;
    assign bus.en_xor_key_i       = en_k;
    assign bus.en_xor_lsb_i       = en_l;
    ascon_perm_engine #(.UNROLL(U_TBL[g]), .ROUNDS_B(RB_TBL[g])) u_dut (
      .clock_i  (clk),
      .resetb_i (rst_n),
      .bus      (bus)
    );
    assign st_o[g]   = bus.state_o;
    assign ci_o[g]   = bus.cipher_o;
    assign tag_o[g]  = bus.tag_o;
    assign busy_o[g] = bus.busy_o;
    assign done_o[g] = bus.done_o;
    assign rnd_o[g]  = bus.round_o;
  end

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [63:0] rotr64(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // Column-wise table lookup model of the permutation, rounds first..11
  function automatic type_state ref_perm(input type_state s, input int first);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [4:0]  col, sb;
    type_state   r;
    x[0] = s.x0; x[1] = s.x1; x[2] = s.x2; x[3] = s.x3; x[4] = s.x4;
    for (int rd = first; rd < 12; rd++) begin
      x[2] ^= 64'((15 - rd) * 16 + rd);
      for (int b = 0; b < 64; b++) begin
        col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
        sb  = SBOX_TBL[col];
        for (int i = 0; i < 5; i++) y[i][b] = sb[4-i];
      end
      for (int i = 0; i < 5; i++) x[i] = y[i] ^ rotr64(y[i], ROT1[i]) ^ rotr64(y[i], ROT2[i]);
    end
    r.x0 = x[0]; r.x1 = x[1]; r.x2 = x[2]; r.x3 = x[3]; r.x4 = x[4];
    return r;
  endfunction

  function automatic exp_t build_exp(input int d, input logic [127:0] prev_tag);
    exp_t      e;
    type_state x, p;
    int        n;
    n = mode ? RB_TBL[d] : 12;
    x = st_in;
    if (en_d) x.x0 ^= data;
    if (en_kf) begin x.x1 ^= key[127:64]; x.x2 ^= key[63:0]; end
    p     = ref_perm(x, 12 - n);
    e.id  = d;
    e.ci  = x.x0;
    e.tag = en_kf ? {p.x3 ^ key[127:64], p.x4 ^ key[63:0]} : prev_tag;
    if (en_k) begin p.x3 ^= key[127:64]; p.x4 ^= key[63:0]; end
    if (en_l) p.x4[0] = ~p.x4[0];
    e.st = p;
    return e;
  endfunction

  function automatic type_state rand_state();
    type_state s;
    s.x0 = {$urandom, $urandom}; s.x1 = {$urandom, $urandom}; s.x2 = {$urandom, $urandom};
    s.x3 = {$urandom, $urandom}; s.x4 = {$urandom, $urandom};
    return s;
  endfunction

  exp_t         sb_q [$];
  exp_t         cur      [NDUT];
  bit           running  [NDUT];
  int           e_acc    [NDUT];
  int           cyc      [NDUT];
  int           r0       [NDUT];
  type_state    hold_st  [NDUT];
  logic [63:0]  hold_ci  [NDUT];
  logic [127:0] hold_tag [NDUT];
  int           ecnt = 0;

  always @(posedge clk) ecnt <= ecnt + 1;

  always @(negedge clk) begin
    bit         mdone;
    int         idx, n;
    exp_t       e;
    logic [3:0] er;
    if (!rst_n) begin
      sb_q.delete();
      for (int d = 0; d < NDUT; d++) begin
        running[d] = 0; hold_st[d] = '0; hold_ci[d] = '0; hold_tag[d] = '0;
      end
    end else begin
      for (int d = 0; d < NDUT; d++) begin
        mdone = 0;
        if (running[d] && ecnt == e_acc[d] + cyc[d]) begin
          running[d] = 0; mdone = 1;
          hold_st[d] = cur[d].st; hold_ci[d] = cur[d].ci; hold_tag[d] = cur[d].tag;
        end
        er = running[d] ? 4'(r0[d] + U_TBL[d] * (ecnt - e_acc[d])) : 4'd0;
        chk($sformatf("done[%0d]", d), done_o[d], mdone);
        chk($sformatf("busy[%0d]", d), busy_o[d], running[d]);
        chk($sformatf("round[%0d]", d), rnd_o[d], er);
        if (!running[d]) begin
          chk($sformatf("idle_state[%0d]", d), st_o[d], hold_st[d]);
          chk($sformatf("idle_cipher[%0d]", d), ci_o[d], hold_ci[d]);
          chk($sformatf("idle_tag[%0d]", d), tag_o[d], hold_tag[d]);
        end
        if (done_o[d]) begin
          idx = -1;
          foreach (sb_q[i]) if (idx < 0 && sb_q[i].id == d) idx = i;
          chk($sformatf("sb_hit[%0d]", d), idx >= 0, 1'b1);
          if (idx >= 0) begin
            e = sb_q[idx];
            sb_q.delete(idx);
            chk($sformatf("sb_state[%0d]", d), st_o[d], e.st);
            chk($sformatf("sb_cipher[%0d]", d), ci_o[d], e.ci);
            chk($sformatf("sb_tag[%0d]", d), tag_o[d], e.tag);
          end
        end
        if (!running[d] && start) begin
          n          = mode ? RB_TBL[d] : 12;
          cur[d]     = build_exp(d, hold_tag[d]);
          sb_q.push_back(cur[d]);
          running[d] = 1;
          e_acc[d]   = ecnt + 1;
          cyc[d]     = n / U_TBL[d];
          r0[d]      = 12 - n;
        end
      end
    end
  end

  task automatic issue(input type_state s, input logic md, input logic [63:0] dt,
                       input logic ed, input logic ekf, input logic ek, input logic el);
    @(posedge clk); #1;
    st_in = s; mode = md; data = dt; en_d = ed; en_kf = ekf; en_k = ek; en_l = el;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    start = 0; mode = 0; en_d = 0; en_kf = 0; en_k = 0; en_l = 0;
    st_in = VEC; data = '0; key = KEY;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", st_o[0], '0);
    chk("rst_cipher", ci_o[0], '0);
    chk("rst_tag", tag_o[0], '0);
    chk("rst_round", rnd_o[0], '0);
    chk("rst_busy", busy_o[0], 1'b0);
    chk("rst_done", done_o[0], 1'b0);
    chk("rc_0", round_const(4'd0), 64'hf0);
    chk("rc_4", round_const(4'd4), 64'hb4);
    chk("rc_6", round_const(4'd6), 64'h96);
    rst_n = 1'b1;

    issue(VEC, 1'b0, '0, 0, 0, 0, 0); settle(14);
    issue(VEC, 1'b0, '0, 0, 0, 1, 0); settle(14);
    issue(VEC, 1'b0, '0, 0, 0, 1, 1); settle(14);
    issue(VEC, 1'b0, {$urandom, $urandom}, 1, 1, 0, 0); settle(14);
    issue(VEC, 1'b1, '0, 0, 0, 0, 0); settle(14);

    // start and new inputs during RUN must be ignored
    issue(VEC, 1'b0, '0, 0, 0, 0, 0);
    repeat (4) @(posedge clk);
    #1; st_in = rand_state(); mode = 1'b1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    settle(14);

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0) key = {$urandom, $urandom, $urandom, $urandom};
      issue(rand_state(), 1'($urandom_range(0, 1)), {$urandom, $urandom},
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      settle($urandom_range(10, 13));
    end

    // start held high: back-to-back acceptance on each done cycle
    key = KEY;
    @(posedge clk); #1; start = 1'b1; mode = 1'b0;
    for (int i = 0; i < 45; i++) begin
      st_in = rand_state(); data = {$urandom, $urandom};
      en_d = 1'($urandom); en_kf = 1'($urandom); en_k = 1'($urandom); en_l = 1'($urandom);
      @(posedge clk); #1;
    end
    start = 1'b0;
    settle(14);

    // asynchronous reset in the middle of a run
    issue(VEC, 1'b0, '0, 0, 0, 0, 0);
    repeat (5) @(posedge clk);
    #2;
    chk("pre_rst_round", rnd_o[0], 4'd5);
    chk("pre_rst_busy", busy_o[0], 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_state", st_o[0], '0);
    chk("mid_rst_cipher", ci_o[0], '0);
    chk("mid_rst_tag", tag_o[0], '0);
    chk("mid_rst_round", rnd_o[0], '0);
    chk("mid_rst_busy", busy_o[0], 1'b0);
    chk("mid_rst_done", done_o[0], 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    issue(VEC, 1'b0, '0, 0, 0, 0, 0); settle(14);

    chk("sb_drained", 320'(sb_q.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ascon_perm_engine.md
ASCON_PERM_ENGINE -- requirements
Module: ascon_perm_engine

Interface
REQ-001 SHALL have parameter UNROLL, default 1, rounds computed per clock; legal values 1 or 2.
REQ-002 SHALL have parameter ROUNDS_B, default 6, rounds for mode pb; legal values 6 or 8.
REQ-003 SHALL have port clock_i  input  1  single clock; all registers on rising edge.
REQ-004 SHALL have port resetb_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start_i  input  1  request to start one permutation.
REQ-006 SHALL have port mode_i  input  1  0 = pa (12 rounds), 1 = pb (ROUNDS_B rounds).
REQ-007 SHALL have port state_i  input  type_state  initial 5x64 state.
REQ-008 SHALL have port data_i  input  64  data word XORed into x0 before the rounds.
REQ-009 SHALL have port key_i  input  128  key; K_hi = bits 127:64, K_lo = bits 63:0.
REQ-010 SHALL have ports en_xor_data_i, en_xor_key_final_i, en_xor_key_i, en_xor_lsb_i  input  1 each  XOR enables, see REQ-016/017.
REQ-011 SHALL have port state_o  output  type_state  current state register.
REQ-012 SHALL have ports cipher_o  output  64  and tag_o  output  128.
REQ-013 SHALL have ports busy_o  output  1, done_o  output  1, and round_o  output  4  current round index.

Function
REQ-014 SHALL implement FSM IDLE/RUN; start_i accepted only in IDLE; start_i in RUN ignored, with no effect on state or latched controls.
REQ-015 SHALL set N = 12 (mode 0) or ROUNDS_B (mode 1); round index runs from 12-N to 11; constant c_r = ((15-r)<<4)|r (r=0 gives 0xf0, r=6 gives 0x96, r=4 gives 0xb4).
REQ-016 SHALL, on the acceptance edge, load state_o = state_i with pre-XORs applied:
  - x0 ^= data_i if en_xor_data_i
  - x1 ^= K_hi and x2 ^= K_lo if en_xor_key_final_i
  - cipher_o <= x0 after the pre-XOR
REQ-017 SHALL latch mode_i, en_xor_key_i, en_xor_lsb_i and en_xor_key_final_i at acceptance; input changes during RUN have no effect.
REQ-018 SHALL apply UNROLL consecutive rounds per RUN cycle and advance round_o by UNROLL.
REQ-019 SHALL, in the same edge that applies the last rounds (acceptance edge k plus N/UNROLL), apply post-XORs:
  - x3 ^= K_hi and x4 ^= K_lo if latched en_xor_key
  - x4 ^= 1 (LSB) if latched en_xor_lsb
  - then return to IDLE.
REQ-020 SHALL, at that completion edge, set tag_o = {x3^K_hi, x4^K_lo} of the permuted state (before post-XORs) if latched en_xor_key_final; otherwise tag_o holds.
REQ-021 SHALL assert done_o for exactly one cycle, after the completion edge; start_i in that cycle SHALL be accepted (back-to-back, zero idle gap).
REQ-022 SHALL drive busy_o high exactly while in RUN; round_o reads 0 in IDLE.
REQ-023 SHALL hold state_o, cipher_o and tag_o stable in IDLE until the next acceptance.

Reset
REQ-024 SHALL, on resetb_i low (including mid-RUN), asynchronously force IDLE and set state_o, cipher_o, tag_o, round_o, busy_o, done_o and all latched controls to 0.
REQ-025 SHALL accept start_i on the first rising edge after resetb_i deasserts.

Structure
REQ-026 SHALL take type_state from ascon_pack and add the following there: ROUNDS_A=12, a round-constant function, the S-box and linear-layer rotation amounts.
REQ-027 SHALL isolate one combinational round (constant addition, S-box, linear diffusion) in sub-module ascon_round, instantiated UNROLL times in a chain.

Verification
REQ-028 SHALL check mode 0, UNROLL=1, all XOR enables low, state_i = {80400c0600000000, 8a55114d1cb6a9a2, be263d4d7aecaaff, 4ed0ec0b98c529b7, c8cddf37bcd0284a}, key 8a55114d1cb6a9a2be263d4d7aecaaff:
  - done_o exactly 12 cycles after acceptance
  - round_o sequence 0..11
  - state_o matches the golden model.
REQ-029 SHALL check the same vector with en_xor_key_i=1: x3/x4 equal the REQ-028 result XOR K_hi/K_lo; with en_xor_lsb_i=1 additionally x4 LSB flipped.
REQ-030 SHALL check mode 1, ROUNDS_B=6:
  - UNROLL=1: round_o starts at 6 (constant 0x96), done after 6 cycles
  - UNROLL=2: done after 3 cycles, same final state
  - ROUNDS_B=8: round_o starts at 4 (constant 0xb4).
REQ-031 SHALL check that start_i pulsed at RUN cycle 4 with changed state_i/mode_i is ignored and the result equals REQ-028.
REQ-032 SHALL check start_i held high continuously: accepted every 13th cycle, done_o pulse coincides with each re-acceptance.
REQ-033 SHALL check resetb_i low at round 5: all outputs 0 immediately, busy_o low; a fresh start afterwards reproduces REQ-028.
